// File: rtl/ysyx_24080014_ifu_if.sv
// rtl/ysyx_24080014_ifu_if.sv - AXI4-Lite read channel bundle between the IFU and instruction memory
//
// Purpose: groups the read-address and read-data channel signals.
// Modports:
//   master - IFU side: drives arvalid/araddr/rready, receives arready/rvalid/rdata/rresp
//   slave  - memory side: the mirror image of master
interface ysyx_24080014_ifu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ysyx_24080014_ifu.sv
// rtl/ysyx_24080014_ifu.sv - instruction fetch unit, one AXI4-Lite read per instruction
//
// Purpose: fetches the word at pc and returns it with a one-cycle inst_ready pulse
// that lets the PC register advance. One transaction outstanding, no prefetch.
// Ports:
//   clk        in   core clock
//   rst        in   asynchronous active-low reset
//   pc         in   current fetch address
//   fetch_en   in   permits a new fetch (sampled in IDLE)
//   inst       out  last fetched instruction (registered)
//   inst_ready out  one-cycle completion pulse
//   inst_fault out  one-cycle fault pulse, coincident with inst_ready
//   axi        master modport of the AXI4-Lite read channel
module ysyx_24080014_ifu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] inst,
  output logic              inst_ready,
  output logic              inst_fault,
  ysyx_24080014_ifu_if.master axi
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;

  logic [1:0]        state_q,      state_d;
  logic [ADDR_W-1:0] araddr_q,     araddr_d;
  logic              arvalid_q,    arvalid_d;
  logic              rready_q,     rready_d;
  logic [DATA_W-1:0] inst_q,       inst_d;
  logic              inst_ready_q, inst_ready_d;
  logic              inst_fault_q, inst_fault_d;

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    inst_d       = inst_q;
    inst_ready_d = 1'b0;
    inst_fault_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // While inst_ready is high the PC register has not yet advanced, so
        // pc is stale; launching now would refetch the same address.
        if (fetch_en && !inst_ready_q) begin
          if (pc[1:0] == 2'b00) begin
            araddr_d  = pc;
            arvalid_d = 1'b1;
            state_d   = S_AR;
          end else begin
            // Misaligned: complete immediately as a fault without touching the bus.
            inst_d       = '0;
            inst_ready_d = 1'b1;
            inst_fault_d = 1'b1;
          end
        end
      end

      S_AR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end

      S_R: begin
        if (axi.rvalid) begin
          rready_d     = 1'b0;
          inst_d       = axi.rdata;
          inst_ready_d = 1'b1;
          inst_fault_d = |axi.rresp;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_q       <= '0;
      inst_ready_q <= 1'b0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_q       <= inst_d;
      inst_ready_q <= inst_ready_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.rready  = rready_q;
  assign inst        = inst_q;
  assign inst_ready  = inst_ready_q;
  assign inst_fault  = inst_fault_q;

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// tb/tb_ysyx_24080014_ifu.sv - directed self-checking bench for the instruction fetch unit
module tb_ysyx_24080014_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_en;
  logic [31:0] inst;
  logic        inst_ready;
  logic        inst_fault;

  ysyx_24080014_ifu_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  ysyx_24080014_ifu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .fetch_en   (fetch_en),
    .inst       (inst),
    .inst_ready (inst_ready),
    .inst_fault (inst_fault),
    .axi        (axi)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // results of the last serve() call
  bit          s_timeout;
  int          s_start;
  int          s_ar_cyc;
  int          s_ar_n;
  int          s_r_n;
  bit          s_stable;
  logic [31:0] s_addr;
  logic        s_rdy;
  logic        s_fault;
  logic [31:0] s_inst;
  int          s_rdy_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory responder for one transaction. Called at a negedge while the IFU is idle;
  // returns at the negedge where inst_ready is expected.
  task automatic serve(input int ar_dly, input int r_dly, input logic [31:0] data,
                       input logic [1:0] resp);
    int t;
    s_timeout = 1'b0;
    s_start   = cyc;
    s_ar_n    = 0;
    s_r_n     = 0;
    s_stable  = 1'b1;
    s_rdy     = 1'b0;
    t = 0;
    while (axi.arvalid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (axi.arvalid !== 1'b1) begin
      s_timeout = 1'b1;
      return;
    end
    s_ar_cyc = cyc;
    s_addr   = axi.araddr;
    do begin
      s_ar_n++;
      if (axi.araddr !== s_addr) s_stable = 1'b0;
      axi.arready = (s_ar_n > ar_dly);
      @(negedge clk);
    end while (axi.arvalid === 1'b1 && s_ar_n < 50);
    axi.arready = 1'b0;
    while (axi.rready === 1'b1 && s_r_n < 50) begin
      s_r_n++;
      if (s_r_n > r_dly) begin
        axi.rvalid = 1'b1;
        axi.rdata  = data;
        axi.rresp  = resp;
      end else begin
        axi.rvalid = 1'b0;
        axi.rdata  = 32'h5A5A_0000 | s_r_n;
        axi.rresp  = 2'b11;
      end
      @(negedge clk);
    end
    axi.rvalid = 1'b0;
    axi.rresp  = 2'b00;
    s_rdy     = inst_ready;
    s_fault   = inst_fault;
    s_inst    = inst;
    s_rdy_cyc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch_en = 1'b0; pc = 32'h8000_0000;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    repeat (3) @(negedge clk);
    if (axi.arvalid !== 1'b0) begin $display("FAIL reset_arvalid: got %b want 0", axi.arvalid); n_fail++; end
    n_cmp++;
    if (axi.rready !== 1'b0) begin $display("FAIL reset_rready: got %b want 0", axi.rready); n_fail++; end
    n_cmp++;
    if (inst_ready !== 1'b0 || inst_fault !== 1'b0) begin
      $display("FAIL reset_pulses: got ready=%b fault=%b want 0 0", inst_ready, inst_fault); n_fail++;
    end
    n_cmp++;
    if (inst !== 32'h0 || axi.araddr !== 32'h0) begin
      $display("FAIL reset_regs: got inst=%h araddr=%h want 0 0", inst, axi.araddr); n_fail++;
    end
    n_cmp++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    if (axi.arvalid !== 1'b0) begin $display("FAIL idle_no_fetch: got arvalid=%b want 0", axi.arvalid); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_first_fetch();
    pc = 32'h8000_0000; fetch_en = 1'b1;
    serve(0, 0, 32'h0010_0093, 2'b00);
    fetch_en = 1'b0;
    if (s_timeout) begin $display("FAIL first_timeout: no arvalid seen"); n_fail++; end
    n_cmp++;
    if (s_addr !== 32'h8000_0000) begin $display("FAIL first_araddr: got %h want 80000000", s_addr); n_fail++; end
    n_cmp++;
    if (s_ar_n !== 1 || s_ar_cyc - s_start !== 1) begin
      $display("FAIL first_ar: got len=%0d at cycle %0d want len=1 at cycle 1", s_ar_n, s_ar_cyc - s_start); n_fail++;
    end
    n_cmp++;
    if (s_rdy !== 1'b1 || s_rdy_cyc - s_start !== 3) begin
      $display("FAIL first_ready: got ready=%b at cycle %0d want 1 at cycle 3", s_rdy, s_rdy_cyc - s_start); n_fail++;
    end
    n_cmp++;
    if (s_inst !== 32'h0010_0093 || s_fault !== 1'b0) begin
      $display("FAIL first_inst: got inst=%h fault=%b want 00100093 0", s_inst, s_fault); n_fail++;
    end
    n_cmp++;
    pc = pc + 32'd4;
    @(negedge clk);
    if (inst_ready !== 1'b0) begin $display("FAIL first_pulse_width: got ready=%b want 0", inst_ready); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    int prev_rdy;
    logic [31:0] want;
    pc = 32'h8000_0000; fetch_en = 1'b1;
    prev_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      serve(0, 0, 32'h0000_0013 + (i << 7), 2'b00);
      want = 32'h8000_0000 + 32'(i * 4);
      if (s_timeout || s_addr !== want) begin
        $display("FAIL b2b_araddr%0d: got %h want %h", i, s_addr, want); n_fail++;
      end
      n_cmp++;
      want = 32'h0000_0013 + 32'(i << 7);
      if (s_rdy !== 1'b1 || s_inst !== want) begin
        $display("FAIL b2b_inst%0d: got ready=%b inst=%h want 1 %h", i, s_rdy, s_inst, want); n_fail++;
      end
      n_cmp++;
      if (i > 0) begin
        if (s_rdy_cyc - prev_rdy !== 4) begin
          $display("FAIL b2b_period%0d: got %0d cycles want 4", i, s_rdy_cyc - prev_rdy); n_fail++;
        end
        n_cmp++;
      end
      prev_rdy = s_rdy_cyc;
      pc = pc + 32'd4;
    end
    fetch_en = 1'b0;
    repeat (2) @(negedge clk);
    if (axi.arvalid !== 1'b0 || inst_ready !== 1'b0) begin
      $display("FAIL b2b_stop: got arvalid=%b ready=%b want 0 0", axi.arvalid, inst_ready); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_wait_states();
    pc = 32'h8000_0100; fetch_en = 1'b1;
    serve(3, 5, 32'h1234_5678, 2'b00);
    fetch_en = 1'b0;
    if (s_timeout || s_ar_n !== 4 || !s_stable || s_addr !== 32'h8000_0100) begin
      $display("FAIL wait_ar: got len=%0d stable=%b addr=%h want 4 1 80000100", s_ar_n, s_stable, s_addr); n_fail++;
    end
    n_cmp++;
    if (s_r_n !== 6) begin $display("FAIL wait_rready: got %0d cycles want 6", s_r_n); n_fail++; end
    n_cmp++;
    if (s_rdy !== 1'b1 || s_inst !== 32'h1234_5678 || s_fault !== 1'b0) begin
      $display("FAIL wait_inst: got ready=%b inst=%h fault=%b want 1 12345678 0", s_rdy, s_inst, s_fault); n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    if (inst_ready !== 1'b0) begin $display("FAIL wait_single_pulse: got ready=%b want 0", inst_ready); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_error_resp();
    pc = 32'h8000_0200; fetch_en = 1'b1;
    serve(0, 0, 32'hDEAD_BEEF, 2'b10);
    fetch_en = 1'b0;
    if (s_timeout || s_rdy !== 1'b1 || s_fault !== 1'b1 || s_inst !== 32'hDEAD_BEEF) begin
      $display("FAIL err_resp: got ready=%b fault=%b inst=%h want 1 1 deadbeef", s_rdy, s_fault, s_inst); n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    if (inst_fault !== 1'b0 || inst !== 32'hDEAD_BEEF) begin
      $display("FAIL err_hold: got fault=%b inst=%h want 0 deadbeef", inst_fault, inst); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_misaligned();
    pc = 32'h8000_0002; fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    if (axi.arvalid !== 1'b0) begin $display("FAIL misalign_arvalid: got %b want 0", axi.arvalid); n_fail++; end
    n_cmp++;
    if (inst !== 32'h0 || inst_ready !== 1'b1 || inst_fault !== 1'b1) begin
      $display("FAIL misalign_pulse: got inst=%h ready=%b fault=%b want 0 1 1", inst, inst_ready, inst_fault); n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    if (axi.arvalid !== 1'b0 || inst_ready !== 1'b0) begin
      $display("FAIL misalign_after: got arvalid=%b ready=%b want 0 0", axi.arvalid, inst_ready); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    int t;
    pc = 32'h8000_0300; fetch_en = 1'b1;
    serve(0, 0, 32'hCAFE_F00D, 2'b00);
    fetch_en = 1'b0;
    pc = 32'h8000_0304;
    @(negedge clk);
    fetch_en = 1'b1;
    t = 0;
    while (axi.arvalid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    if (axi.rready !== 1'b1) begin $display("FAIL rst_mid_in_r: got rready=%b want 1", axi.rready); n_fail++; end
    n_cmp++;
    axi.rvalid = 1'b1; axi.rdata = 32'h1111_1111;
    #2 rst = 1'b0;
    #1;
    if (axi.rready !== 1'b0 || axi.arvalid !== 1'b0 || inst_ready !== 1'b0) begin
      $display("FAIL rst_mid_drop: got rready=%b arvalid=%b ready=%b want 0 0 0",
               axi.rready, axi.arvalid, inst_ready); n_fail++;
    end
    n_cmp++;
    if (inst !== 32'h0) begin $display("FAIL rst_mid_inst: got %h want 0", inst); n_fail++; end
    n_cmp++;
    @(negedge clk);
    axi.rvalid = 1'b0;
    pc = 32'h8000_0000;
    @(negedge clk);
    rst = 1'b1;
    serve(0, 0, 32'h0000_0513, 2'b00);
    fetch_en = 1'b0;
    if (s_timeout || s_addr !== 32'h8000_0000 || s_ar_cyc - s_start !== 1) begin
      $display("FAIL rst_refetch_addr: got %h at cycle %0d want 80000000 at cycle 1", s_addr, s_ar_cyc - s_start); n_fail++;
    end
    n_cmp++;
    if (s_rdy !== 1'b1 || s_inst !== 32'h0000_0513) begin
      $display("FAIL rst_refetch_inst: got ready=%b inst=%h want 1 00000513", s_rdy, s_inst); n_fail++;
    end
    n_cmp++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_fetch();
    @(negedge clk);
    test_back_to_back();
    test_wait_states();
    @(negedge clk);
    test_error_resp();
    @(negedge clk);
    test_misaligned();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24080014_ifu.md
# ysyx_24080014_ifu

Instruction fetch unit for the single-cycle-issue NPC core. It takes the current `pc` from the PC register, performs one AXI4-Lite read per instruction to instruction memory, and returns the fetched word together with a one-cycle `inst_ready` pulse. The PC register consumes that pulse to advance to `next_pc`. The block therefore closes the fetch handshake that the PC register initiates, and it owns the memory-side read channel.

## Interface
Parameters:
- `ADDR_W`, default 32: width of `pc` and `araddr`.
- `DATA_W`, default 32: instruction and `rdata` width.

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; 0 = reset.
- `pc`  in  ADDR_W  current fetch address from the PC register.
- `fetch_en`  in  1  downstream permits a new fetch; sampled in IDLE only.
- `inst`  out  DATA_W  last fetched instruction, registered.
- `inst_ready`  out  1  one-cycle pulse: `inst` is valid and the PC register may update.
- `inst_fault`  out  1  one-cycle pulse coincident with `inst_ready` when the fetch failed.
- `arvalid`  out  1  AXI read-address valid.
- `arready`  in  1  AXI read-address ready.
- `araddr`  out  ADDR_W  AXI read address, registered.
- `rvalid`  in  1  AXI read-data valid.
- `rready`  out  1  AXI read-data ready.
- `rdata`  in  DATA_W  AXI read data.
- `rresp`  in  2  AXI read response; any nonzero value is an error.

## Operation
- FSM states: IDLE, AR, R.
- IDLE:
  - If `fetch_en`=1 and `pc[1:0]`=0: capture `araddr`<=`pc`, go to AR.
  - If `fetch_en`=1 and `pc[1:0]`!=0 (misaligned): issue no bus access. Set `inst`<=0, pulse `inst_ready` and `inst_fault`, and stay in IDLE.
  - If `fetch_en`=0: stay in IDLE.
- AR: `arvalid`=1. `araddr` is held stable until the handshake. On `arvalid & arready`, go to R.
- R: `rready`=1. On `rvalid & rready`:
  - `inst`<=`rdata`, regardless of `rresp`.
  - `inst_ready`<=1 for one cycle.
  - `inst_fault`<=(`rresp`!=0).
  - Go to IDLE.
- `inst_ready` and `inst_fault` are registered pulses. They are high during the first IDLE cycle after completion, and the PC register updates `pc` at the end of that cycle.
- Consequently, IDLE never launches a new fetch in the same cycle that `inst_ready` is high, because `pc` is still stale. The FSM waits one cycle (`inst_ready` low) before sampling `pc`.
- `inst` holds its value until the next completion.
- Only one transaction is outstanding at a time; there is no prefetch.
- Reset (`rst`=0, asynchronous):
  - State returns to IDLE.
  - `arvalid`=0, `rready`=0, `inst_ready`=0, `inst_fault`=0, `inst`=0, `araddr`=0.
- Reset mid-transaction abandons the access. Memory shares the same reset, so no response is expected afterwards.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Minimum fetch loop, with `arready`=1 immediately and `rvalid` one cycle later:
  - cycle 0: IDLE, sample `pc`
  - cycle 1: AR, `arvalid`
  - cycle 2: R, `rvalid`
  - cycle 3: IDLE, `inst_ready`=1
  - cycle 4: IDLE, fetch of the new `pc`
- Steady state is 4 cycles per instruction.
- `arvalid` may see `arready` in its first cycle. The bus may insert any number of wait states on either channel; `arvalid`/`araddr` and `rready` remain asserted and stable throughout.
- An `rvalid` seen outside state R is ignored (`rready`=0 there).
- `fetch_en` deasserted while in AR or R does not abort the transaction. It only blocks the next launch from IDLE.
- After reset release, the first fetch starts in the first cycle where `rst`=1 and `fetch_en`=1. It uses `pc`, which the PC register resets to 0x80000000.

## Test plan
- Reset then `fetch_en`=1, `pc`=0x80000000, memory with zero wait and word 0x00100093 -> `araddr`=0x80000000, `arvalid` for 1 cycle, `inst_ready` pulses in cycle 3 with `inst`=0x00100093 and `inst_fault`=0.
- Back-to-back fetches with a PC register model (`next_pc`=`pc`+4) -> `araddr` sequence 0x80000000, 0x80000004, 0x80000008, one `inst_ready` every 4 cycles, and no `araddr` repeats.
- `arready` delayed 3 cycles and `rvalid` delayed 5 cycles -> `araddr` stable and `arvalid` high for 4 cycles, `rready` high for 6 cycles, exactly one `inst_ready` pulse.
- `rresp`=2'b10 with `rdata`=0xDEADBEEF -> `inst`=0xDEADBEEF, `inst_ready`=1 and `inst_fault`=1 in the same cycle.
- `pc`=0x80000002 with `fetch_en`=1 -> `arvalid` never asserts, next cycle `inst`=0, `inst_ready`=1, `inst_fault`=1.
- `rst` pulled low while in R with `rvalid` pending -> `rready`, `arvalid` and `inst_ready` drop immediately and `inst`=0. After release the unit refetches from 0x80000000.
